vcr_ugal_sniffer: RTL

//  Tracks downstream buffer occupancy per network output port of a router.

---
 rtl/vcr_ugal_sniffer_pkg.sv | 45 ++++
 rtl/vcr_ugal_port_tracker.sv | 106 ++++++++++
 rtl/vcr_ugal_sniffer.sv | 63 ++++++
 3 files changed

// File: rtl/vcr_ugal_sniffer_pkg.sv
// ============================================================================
//  Module : vcr_ugal_sniffer_pkg
//  Brief  : Shared constants, helper functions and types for the UGAL sniffer.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package vcr_ugal_sniffer_pkg;

    localparam int c_connectivity_line = 0;
    localparam int c_connectivity_ring = 1;
    localparam int c_connectivity_full = 2;

    typedef struct packed {
        logic ovf;
        logic unf;
        logic proto;
    } err_flags_t;

    // Ceiling log2; clogb(1) == 0.
    function automatic int clogb(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    function automatic int neighbors_per_dim(input int connectivity, input int routers_per_dim);
        int result;
        case (connectivity)
            c_connectivity_line: result = 2;
            c_connectivity_ring: result = 2;
            default:             result = routers_per_dim - 1;
        endcase
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vcr_ugal_port_tracker.sv
// ============================================================================
//  Module : vcr_ugal_port_tracker
//  Brief  : Per-VC downstream occupancy counters, aggregate and sticky errors
//           for one network output port.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vcr_ugal_port_tracker
    import vcr_ugal_sniffer_pkg::*;
#(
    parameter int NUM_VCS          = 2,
    parameter int NUM_FLIT_BUFFERS = 8,
    parameter int CNT_W            = 4,
    parameter int CCW              = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flit_valid,
    input  logic [NUM_VCS-1:0] flit_vc,
    input  logic               credit_valid,
    input  logic [NUM_VCS-1:0] credit_vc,
    output logic [CCW-1:0]     credit_count,
    output logic               error_ovf,
    output logic               error_unf,
    output logic               error_proto
);

    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(NUM_FLIT_BUFFERS);

    logic [CNT_W-1:0]   r_vc_cnt [NUM_VCS];
    logic [CCW-1:0]     r_count;
    err_flags_t         r_err;

    logic               w_flit_onehot;
    logic               w_credit_onehot;
    logic [NUM_VCS-1:0] w_flit_hit;
    logic [NUM_VCS-1:0] w_credit_hit;
    logic [NUM_VCS-1:0] w_inc;
    logic [NUM_VCS-1:0] w_dec;
    logic               w_ovf;
    logic               w_unf;
    logic               w_any_inc;
    logic               w_any_dec;

    assign w_flit_onehot   = (flit_vc != '0) && ((flit_vc & (flit_vc - NUM_VCS'(1))) == '0);
    assign w_credit_onehot = (credit_vc != '0) && ((credit_vc & (credit_vc - NUM_VCS'(1))) == '0);

    // Malformed strobes are dropped entirely; only well-formed events reach the counters.
    assign w_flit_hit   = flit_vc & {NUM_VCS{flit_valid && w_flit_onehot}};
    assign w_credit_hit = credit_vc & {NUM_VCS{credit_valid && w_credit_onehot}};

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        w_ovf = 1'b0;
        w_unf = 1'b0;
        for (int v = 0; v < NUM_VCS; v++) begin
            // A flit and credit on the same VC cancel out without any range check.
            if (w_flit_hit[v] && !w_credit_hit[v]) begin
                if (r_vc_cnt[v] == c_cnt_max) w_ovf    = 1'b1;
                else                          w_inc[v] = 1'b1;
            end
            if (w_credit_hit[v] && !w_flit_hit[v]) begin
                if (r_vc_cnt[v] == '0) w_unf    = 1'b1;
                else                   w_dec[v] = 1'b1;
            end
        end
    end

    assign w_any_inc = |w_inc;
    assign w_any_dec = |w_dec;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int v = 0; v < NUM_VCS; v++) begin
                r_vc_cnt[v] <= '0;
            end
            r_count <= '0;
            r_err   <= '0;
        end else begin
            for (int v = 0; v < NUM_VCS; v++) begin
                if (w_inc[v])      r_vc_cnt[v] <= r_vc_cnt[v] + CNT_W'(1);
                else if (w_dec[v]) r_vc_cnt[v] <= r_vc_cnt[v] - CNT_W'(1);
            end
            // At most one increment and one decrement per cycle, so the sum moves by +-1.
            case ({w_any_inc, w_any_dec})
                2'b10:   r_count <= r_count + CCW'(1);
                2'b01:   r_count <= r_count - CCW'(1);
                default: r_count <= r_count;
            endcase
            r_err.ovf   <= r_err.ovf   | w_ovf;
            r_err.unf   <= r_err.unf   | w_unf;
            r_err.proto <= r_err.proto | (flit_valid && !w_flit_onehot)
                                       | (credit_valid && !w_credit_onehot);
        end
    end

    assign credit_count = r_count;
    assign error_ovf    = r_err.ovf;
    assign error_unf    = r_err.unf;
    assign error_proto  = r_err.proto;

endmodule

`default_nettype wire

// File: rtl/vcr_ugal_sniffer.sv
// ============================================================================
//  Module : vcr_ugal_sniffer
//  Brief  : Per-port downstream buffer occupancy for UGAL congestion sensing;
//           one tracker per network output port.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vcr_ugal_sniffer
    import vcr_ugal_sniffer_pkg::*;
#(
    parameter int NUM_FLIT_BUFFERS     = 8,
    parameter int NUM_MESSAGE_CLASSES  = 1,
    parameter int NUM_RESOURCE_CLASSES = 2,
    parameter int NUM_VCS_PER_CLASS    = 1,
    parameter int NUM_ROUTERS_PER_DIM  = 4,
    parameter int NUM_DIMENSIONS       = 2,
    parameter int NUM_NODES_PER_ROUTER = 4,
    parameter int CONNECTIVITY         = c_connectivity_full,
    localparam int c_num_vcs           = NUM_MESSAGE_CLASSES * NUM_RESOURCE_CLASSES * NUM_VCS_PER_CLASS,
    localparam int c_num_nbr_per_dim   = neighbors_per_dim(CONNECTIVITY, NUM_ROUTERS_PER_DIM),
    localparam int c_num_ports         = NUM_DIMENSIONS * c_num_nbr_per_dim + NUM_NODES_PER_ROUTER,
    localparam int c_p                 = c_num_ports - NUM_NODES_PER_ROUTER,
    localparam int c_ccw               = clogb(c_num_vcs * NUM_FLIT_BUFFERS) + 1,
    localparam int c_cnt_w             = clogb(NUM_FLIT_BUFFERS + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [c_p-1:0]             flit_valid_out,
    input  logic [c_p*c_num_vcs-1:0]   flit_vc_out,
    input  logic [c_p-1:0]             credit_valid_in,
    input  logic [c_p*c_num_vcs-1:0]   credit_vc_in,
    output logic [c_p*c_ccw-1:0]       credit_count,
    output logic [c_p-1:0]             error_ovf,
    output logic [c_p-1:0]             error_unf,
    output logic [c_p-1:0]             error_proto
);

    generate
        for (genvar p = 0; p < c_p; p++) begin : g_port
            vcr_ugal_port_tracker #(
                .NUM_VCS          (c_num_vcs),
                .NUM_FLIT_BUFFERS (NUM_FLIT_BUFFERS),
                .CNT_W            (c_cnt_w),
                .CCW              (c_ccw)
            ) u_tracker (
                .clk          (clk),
                .reset        (reset),
                .flit_valid   (flit_valid_out[p]),
                .flit_vc      (flit_vc_out[p*c_num_vcs +: c_num_vcs]),
                .credit_valid (credit_valid_in[p]),
                .credit_vc    (credit_vc_in[p*c_num_vcs +: c_num_vcs]),
                .credit_count (credit_count[p*c_ccw +: c_ccw]),
                .error_ovf    (error_ovf[p]),
                .error_unf    (error_unf[p]),
                .error_proto  (error_proto[p])
            );
        end
    endgenerate

endmodule

`default_nettype wire
